// File: rtl/comunicaciones_pkg.sv
// comunicaciones_pkg: shared FSM states, frame word indices and word-length helper.
// PARITY_EN adds the parity state and one bit to every serial word.
package comunicaciones_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP,
        NEXT,
        DONE
    } state_t;

    localparam int FRAME_WORDS = 3;
    localparam logic [1:0] IDX_SYNC = 2'd0;
    localparam logic [1:0] IDX_CMD  = 2'd1;
    localparam logic [1:0] IDX_CHK  = 2'd2;

    function automatic int word_bits(input int data_bits, input int stop_bits);
`ifdef PARITY_EN
        return 2 + data_bits + stop_bits;
`else
        return 1 + data_bits + stop_bits;
`endif
    endfunction

endpackage

// File: rtl/comunicaciones_cmd_fifo.sv
// comunicaciones_cmd_fifo: synchronous command FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module comunicaciones_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             wr_en, rd_en;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

endmodule

// File: rtl/comunicaciones_frame_tx.sv
// comunicaciones_frame_tx: queues strobed commands and sends each as a UART-style
// SYNC/command/checksum frame. Define PARITY_EN to append an even parity bit per word.
module comunicaciones_frame_tx
    import comunicaciones_pkg::*;
#(
    parameter int             CLK_DIV   = 434,
    parameter int             DATA_BITS = 8,
    parameter int             STOP_BITS = 1,
    parameter int             CMD_DEPTH = 4,
    parameter logic [7:0]     SYNC_WORD = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] command,
    input  logic                 str,
    output logic                 tx,
    output logic                 ready_command,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 cmd_drop
);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [DATA_BITS-1:0] SYNC = SYNC_WORD[DATA_BITS-1:0];

    state_t               state;
    logic                 str_q, push, pop, full, empty, bit_end;
    logic [DATA_BITS-1:0] fifo_dout, cmd_r, shreg, chk;
    logic [BW-1:0]        baud;
    logic [2:0]           bit_cnt;
    logic [1:0]           word_idx;
`ifdef PARITY_EN
    logic                 par;
`endif

    assign push      = str & ~str_q;
    assign pop       = ~empty & (state == IDLE || state == DONE);
    assign bit_end   = baud == BW'(CLK_DIV - 1);
    assign fifo_full = full;

    comunicaciones_cmd_fifo #(.WIDTH(DATA_BITS), .DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (command),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            str_q         <= 1'b0;
            state         <= IDLE;
            tx            <= 1'b1;
            ready_command <= 1'b0;
            busy          <= 1'b0;
            cmd_drop      <= 1'b0;
            baud          <= '0;
            bit_cnt       <= '0;
            word_idx      <= IDX_SYNC;
            cmd_r         <= '0;
            shreg         <= '0;
            chk           <= '0;
`ifdef PARITY_EN
            par           <= 1'b0;
`endif
        end else begin
            str_q         <= str;
            ready_command <= 1'b0;
            cmd_drop      <= push & full & ~pop;
            baud          <= (bit_end || state == IDLE || state == LOAD || state == DONE) ? '0 : baud + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (!empty) begin
                        cmd_r <= fifo_dout;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    word_idx <= IDX_SYNC;
                    shreg    <= SYNC;
                    chk      <= SYNC ^ cmd_r;
                    tx       <= 1'b0;
                    state    <= START;
                end
                START: begin
`ifdef PARITY_EN
                    par <= 1'b0;
`endif
                    if (bit_end) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
`ifdef PARITY_EN
                        par   <= par ^ shreg[0];
`endif
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
`ifdef PARITY_EN
                            tx      <= par ^ shreg[0];
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                // The next-word decision is taken on the final stop cycle so words abut.
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (word_idx == IDX_CHK) begin
                                ready_command <= 1'b1;
                                busy          <= 1'b0;
                                state         <= DONE;
                            end else begin
                                shreg    <= (word_idx == IDX_SYNC) ? cmd_r : chk;
                                word_idx <= word_idx + 1'b1;
                                tx       <= 1'b0;
                                state    <= START;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comunicaciones_frame_tx.sv
// tb_comunicaciones_frame_tx: decodes the serial line with a behavioural UART receiver
// and compares the received words with frames predicted from the accepted commands.
module tb_comunicaciones_frame_tx;
    import comunicaciones_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int CMD_DEPTH = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int WB    = word_bits(DATA_BITS, STOP_BITS);
    localparam int FRAME = FRAME_WORDS * WB * CLK_DIV;

    logic       clk = 1'b0, rst = 1'b1, str = 1'b0;
    logic [7:0] command = 8'h00;
    logic       tx, ready_command, busy, fifo_full, cmd_drop;

    int tests = 0, fails = 0;
    int cyc = 0, rdy_cnt = 0, rdy_cyc = 0, drop_cnt = 0;
    int pos = -1;
    int rx_rd = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    comunicaciones_frame_tx #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .CMD_DEPTH (CMD_DEPTH),
        .SYNC_WORD (SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .command       (command),
        .str           (str),
        .tx            (tx),
        .ready_command (ready_command),
        .busy          (busy),
        .fifo_full     (fifo_full),
        .cmd_drop      (cmd_drop)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver samples each bit at its middle, counting from the first low half-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ready_command) begin
            rdy_cnt <= rdy_cnt + 1;
            rdy_cyc <= cyc;
        end
        if (cmd_drop)
            drop_cnt <= drop_cnt + 1;
        if (rst) begin
            pos <= -1;
        end else if (pos < 0) begin
            if (tx == 1'b0)
                pos <= 1;
        end else begin
            if (pos % CLK_DIV == CLK_DIV / 2) begin
                if (pos / CLK_DIV == 0)
                    check("start_bit", 32'(tx), 32'd0);
                else if (pos / CLK_DIV <= DATA_BITS)
                    sh[pos / CLK_DIV - 1] <= tx;
`ifdef PARITY_EN
                else if (pos / CLK_DIV == DATA_BITS + 1)
                    check("parity_bit", 32'(tx), 32'(^sh));
`endif
                else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (pos / CLK_DIV == WB - STOP_BITS)
                        rx_q.push_back(sh);
                end
            end
            pos <= (pos == WB * CLK_DIV - 1) ? -1 : pos + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] c, input int hold);
        command = c;
        str = 1'b1;
        step(hold);
        str = 1'b0;
        step(1);
    endtask

    task automatic expect_frame(input logic [7:0] c);
        exp_q.push_back(SYNC);
        exp_q.push_back(c);
        exp_q.push_back(SYNC ^ c);
    endtask

    task automatic wait_rdy(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (rdy_cnt < target && n < budget) begin
            step(1);
            n++;
        end
        check({tag, "_ready_count"}, 32'(rdy_cnt), 32'(target));
    endtask

    task automatic compare_rx(input string tag);
        int got_n;
        got_n = rx_q.size() - rx_rd;
        check({tag, "_word_count"}, 32'(got_n), 32'(exp_q.size()));
        for (int i = 0; i < got_n && i < exp_q.size(); i++)
            check({tag, "_word"}, 32'(rx_q[rx_rd + i]), 32'(exp_q[i]));
        rx_rd = rx_q.size();
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, n0, d0, n, acc;
        logic [7:0] c;

        step(5);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready_command), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_drop", 32'(cmd_drop), 32'd0);
        rst = 1'b0;
        step(2);

        // single command, latency and frame length
        base = rdy_cnt;
        command = 8'h01;
        str = 1'b1;
        step(1);
        check("lat_e1", 32'(tx), 32'd1);
        step(1);
        check("lat_e2", 32'(tx), 32'd1);
        step(1);
        check("lat_e3", 32'(tx), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        n0 = cyc;
        step(2);
        str = 1'b0;
        expect_frame(8'h01);
        wait_rdy("t1", base + 1, FRAME + 50);
        check("t1_len", 32'(rdy_cyc - n0), 32'(FRAME));
        step(10);
        check("t1_once", 32'(rdy_cnt), 32'(base + 1));
        check("t1_idle_busy", 32'(busy), 32'd0);
        compare_rx("t1");

        // four spaced commands run as consecutive frames
        base = rdy_cnt;
        for (int i = 0; i < 4; i++) begin
            strobe(8'(i), 1);
            expect_frame(8'(i));
            step(8);
        end
        wait_rdy("t2", base + 4, 4 * FRAME + 100);
        step(5);
        compare_rx("t2");

        // overflow: one popped, CMD_DEPTH queued, the rest dropped
        base = rdy_cnt;
        d0 = drop_cnt;
        for (int i = 0; i < 6; i++) begin
            strobe(8'h10 + 8'(i), 1);
            step(1);
            if (i < CMD_DEPTH + 1)
                expect_frame(8'h10 + 8'(i));
        end
        check("t3_full", 32'(fifo_full), 32'd1);
        check("t3_drops", 32'(drop_cnt - d0), 32'd1);
        wait_rdy("t3", base + 5, 5 * FRAME + 100);
        step(FRAME);
        check("t3_no_extra", 32'(rdy_cnt), 32'(base + 5));
        compare_rx("t3");

        // reset 50 cycles into a frame with two commands queued behind it
        base = rdy_cnt;
        strobe(8'h3C, 1);
        strobe(8'h5A, 1);
        strobe(8'hC3, 1);
        step(47);
        rst = 1'b1;
        step(1);
        check("t4_tx", 32'(tx), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_full", 32'(fifo_full), 32'd0);
        check("t4_ready", 32'(ready_command), 32'd0);
        rst = 1'b0;
        exp_q.push_back(SYNC);
        step(3 * FRAME);
        check("t4_no_ready", 32'(rdy_cnt), 32'(base));
        check("t4_idle", 32'(busy), 32'd0);
        compare_rx("t4");

        // long strobe queues one command
        base = rdy_cnt;
        strobe(8'h02, 1000);
        expect_frame(8'h02);
        wait_rdy("t5", base + 1, 100);
        step(2 * FRAME);
        check("t5_once", 32'(rdy_cnt), 32'(base + 1));
        compare_rx("t5");

        // random bursts from idle; capacity is one in flight plus CMD_DEPTH queued
        for (int r = 0; r < 10; r++) begin
            base = rdy_cnt;
            d0 = drop_cnt;
            n = $urandom_range(1, 7);
            acc = (n < CMD_DEPTH + 1) ? n : CMD_DEPTH + 1;
            for (int i = 0; i < n; i++) begin
                c = 8'($urandom);
                strobe(c, $urandom_range(1, 2));
                if (i < acc)
                    expect_frame(c);
            end
            repeat (20) begin
                command = 8'($urandom);
                step(1);
            end
            wait_rdy("rnd", base + acc, acc * FRAME + 100);
            check("rnd_drops", 32'(drop_cnt - d0), 32'(n - acc));
            step(5);
            compare_rx("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comunicaciones_frame_tx.md
Name: comunicaciones_frame_tx

Overview:
Parametrised successor to the single-command UART link. Queues command words on rising edges of `str` in a small command FIFO. Sends each command as a 3-word framed packet: SYNC, command, checksum. Serialisation is UART-style on `tx` with configurable baud divisor, data width and stop bits. Sits between the J1 SoC command register and the external serial line; pulses `ready_command` when each frame completes.

Parameters:
CLK_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535
DATA_BITS, 8, bits per serial word, 5..8; also width of command, SYNC and checksum
STOP_BITS, 1, number of stop bits, 1 or 2
CMD_DEPTH, 4, command FIFO depth, power of two, 2..16
SYNC_WORD, 8'hA5, first word of every frame, truncated to DATA_BITS LSBs

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
command  in  DATA_BITS  command word, sampled on the cycle a `str` rising edge is detected
str  in  1  strobe, level input; only its rising edge queues a command
tx  out  1  serial output, idle high
ready_command  out  1  one-cycle pulse when the last stop bit of a frame ends
busy  out  1  high while a frame is being transmitted
fifo_full  out  1  command FIFO holds CMD_DEPTH entries
cmd_drop  out  1  one-cycle pulse when a `str` edge is rejected because the FIFO is full

Behaviour:
- Reset values: tx=1, ready_command=0, busy=0, fifo_full=0, cmd_drop=0. FIFO is emptied, `str` edge register=0, FSM=IDLE, baud and bit counters=0.
- Edge detect: `str_q` registered each cycle; push when `str & ~str_q`. A strobe held high for many cycles queues exactly one command.
- Push while full is rejected and pulses cmd_drop, unless a pop happens in the same cycle; that push is accepted and count is unchanged.
- FSM states: IDLE, LOAD, START, DATA, STOP, NEXT, DONE.
- IDLE: if FIFO non-empty, pop into `cmd_r` and go to LOAD; busy=1 from LOAD onward.
- LOAD: set `word_idx=0`, `shreg=SYNC_WORD`, checksum `chk=SYNC_WORD ^ cmd_r`; go to START.
- Timing from an empty FIFO: the edge is seen at cycle E, the push lands at E+1, IDLE pops at E+1, LOAD runs at E+2, and tx goes low at E+3.
- START: tx=0 for CLK_DIV cycles, then DATA.
- DATA: tx=shreg[0], sent LSB first; each bit lasts CLK_DIV cycles; shift after each bit. After DATA_BITS bits go to STOP.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then NEXT.
- NEXT, word_idx 0: load cmd_r, go to START.
- NEXT, word_idx 1: load chk, go to START.
- NEXT, word_idx 2: go to DONE.
- NEXT adds no tx cycle: it is merged with the final STOP cycle, so words are back-to-back with no idle gap.
- DONE: ready_command=1 for one cycle, busy=0. If the FIFO is non-empty, pop in the same cycle and go to LOAD; else go to IDLE.
- Frame length: 3*(1+DATA_BITS+STOP_BITS)*CLK_DIV cycles.
- Baud counter counts 0..CLK_DIV-1 and wraps; width is $clog2(CLK_DIV).
- Reset mid-frame: the frame is aborted, tx=1 on the next cycle, no ready_command pulse, and queued commands are discarded.
- A `command` change without a `str` edge has no effect; queued values are stable copies.

Optional Feature:
PARITY_EN:
- Defined: a PARITY state sits between DATA and STOP and sends an even parity bit (XOR of data bits) for CLK_DIV cycles. Word length becomes 2+DATA_BITS+STOP_BITS bits.
- Undefined: no parity state and no parity logic.

Decomposition:
- Package `comunicaciones_pkg`:
  - FSM state enum;
  - frame word index constants (IDX_SYNC=0, IDX_CMD=1, IDX_CHK=2);
  - FRAME_WORDS=3;
  - function `word_bits(data_bits, stop_bits)`.
- Sub-module `comunicaciones_cmd_fifo`: synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty and simultaneous push-pop support, instantiated once.

Test Plan:
1. Setup CLK_DIV=4, DATA_BITS=8, STOP_BITS=1, CMD_DEPTH=4. Stimulus: rst 5 cycles, command=8'h01, `str` high for 5 cycles. Response: tx low at E+3; frame carries A5, 01, A4 LSB first, 40 cycles per word. ready_command pulses once, 120 cycles after tx first falls.
2. Stimulus: 4 `str` edges, 10 cycles apart, commands 00..03, while idle. Response: 4 frames back-to-back, no idle gap; checksums A5, A4, A7, A6; 4 ready_command pulses.
3. Stimulus: 6 `str` edges within 20 cycles, commands 10..15. Response: first pops immediately and 4 are queued; the 6th pulses cmd_drop and fifo_full is high. Only 5 frames are sent.
4. Stimulus: assert rst at cycle 50 of a frame. Response: tx=1 next cycle, busy=0, no ready_command, FIFO empty, and no further frames.
5. Stimulus: hold `str` high for 1000 cycles with command=8'h02. Response: exactly one frame, A5 02 A7.
6. With PARITY_EN, command=8'h01. Response: parity bits 0, 1, 1 for words A5, 01, A4; word length 44 cycles; ready_command 132 cycles after the first start bit.
